fsm_input_conditioner: RTL and testbench
========================================

Name: fsm_input_conditioner

Overview:
Upstream stage of the vending-machine FSM top. It takes the raw asynchronous coin, accepted and two reset pushbutton inputs from the board pins. Each input is synchronised to clk, debounced with a per-channel stability counter, and presented to the FSM as a clean level plus single-cycle rise and fall pulses. The FSM's m, a, btnC and btnD inputs connect to this block's level or rise outputs, bit 0 to bit 3 in that order.

Parameters:
N_CH, 4, number of independent input channels (bit 0 coin, bit 1 accepted, bit 2 btnC, bit 3 btnD).
DEBOUNCE_CYCLES, 16, consecutive synchronised-mismatch cycles needed to accept a new level; legal range 2..65535.
CNT_W, derived as ceil(log2(DEBOUNCE_CYCLES)) with minimum 1; localparam giving the per-channel counter width; not overridable.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
ena  input  1  conditioning enable; low freezes the debounce counters and suppresses pulses.
raw_in  input  N_CH  asynchronous raw pin levels.
level_out  output  N_CH  debounced stable level per channel.
rise_out  output  N_CH  one-cycle pulse when level_out goes 0 to 1.
fall_out  output  N_CH  one-cycle pulse when level_out goes 1 to 0.
busy_out  output  N_CH  high while that channel's counter is nonzero, i.e. a change is pending.
any_rise  output  1  OR-reduction of rise_out.

Behaviour:
- Reset (rst=1 at an edge):
  - clears both synchroniser stages, level_out, counters, rise_out and fall_out to 0.
  - busy_out and any_rise therefore read 0 in the following cycle.
  - rst overrides ena and raw_in.
  - Reset mid-count discards the pending change; there is no pulse.
- Synchroniser: per channel, 2-flop chain raw_in -> s1 -> s2. It always runs when not in reset, regardless of ena.
- Debounce per channel, evaluated each edge while ena=1:
  - s2 == level_out: counter <= 0.
  - s2 != level_out and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != level_out and counter == DEBOUNCE_CYCLES-1: level_out <= s2 and counter <= 0. rise_out is set if s2=1; fall_out is set if s2=0.
- Latency:
  - Raw change first sampled by s1 at edge k: level_out updates at edge k+DEBOUNCE_CYCLES+1.
  - This is DEBOUNCE_CYCLES+2 edges counting k as the first.
  - The pulse is registered and asserted in the same cycle level_out first shows the new value.
- Pulses are exactly one cycle wide and are deasserted on the next edge unconditionally.
- rise_out and fall_out are never both high for one channel.
- Glitch rejection: any s2 mismatch run shorter than DEBOUNCE_CYCLES cycles returns the counter to 0 on the first matching cycle, with no level change and no pulse.
- A counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.
- ena=0:
  - counters and level_out hold.
  - rise_out and fall_out are forced 0 on the next edge.
  - When ena returns to 1, counting resumes from the held value.
- Channels are fully independent. Simultaneous qualifying changes on several channels produce pulses in the same cycle, and any_rise=1 for that cycle.
- busy_out and any_rise are combinational from registered state.

Test Plan:
- DEBOUNCE_CYCLES=4, reset then raw_in[0] 0->1 held, first sampled at edge 1 -> level_out[0]=1 and rise_out[0]=1 after edge 6; rise_out[0]=0 after edge 7; any_rise=1 only in the cycle after edge 6.
- DEBOUNCE_CYCLES=4, raw_in[1] high for exactly 3 cycles then low -> busy_out[1] rises then returns to 0; level_out[1], rise_out[1] and fall_out[1] stay 0 throughout.
- Channel 2 settled at 1, raw_in[2] driven to 0 and held -> fall_out[2] pulses one cycle, 6 edges after first sampling; level_out[2]=0; rise_out[2] stays 0.
- raw_in[3] rises and rst=1 at the 4th edge -> all outputs 0 after that edge. With raw still high after rst release, the level change takes a full 6 edges counted from the release; exactly one rise pulse.
- ena=0 asserted when the counter = 2, held 10 cycles, then ena=1 -> level_out updates exactly 2 edges after ena returns; no pulse while ena=0.
- raw_in = 4'b1111 in one cycle from reset -> all four rise_out bits pulse in the same cycle; level_out = 4'b1111; any_rise=1 for one cycle.

Source files
------------

// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner
// This block conditions the raw board inputs for the vending-machine FSM.
// The inputs are coin, accepted, btnC and btnD, in bit order 0 to 3.
// Each channel goes through the following stages:
//   - a two-flop synchroniser;
//   - a per-channel stability counter;
//   - a registered clean level, plus single-cycle rise and fall pulses.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with the current level.
module fsm_input_conditioner #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] busy_out,
  output logic            any_rise
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1, so ceil(log2) bits suffice.
  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0]  s1_q, s1_d;
  logic [N_CH-1:0]  s2_q, s2_d;
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Next-state logic: the synchroniser always shifts; debounce and pulses advance only while enabled.
  always_comb begin
    s1_d    = raw_in;
    s2_d    = s1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ena) begin
        if (s2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s2_q[i];
          cnt_d[i]   = '0;
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // State registers: a synchronous reset clears everything, which drops any pending change silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // busy_out marks a pending change (nonzero counter); any_rise summarises the rise pulses.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      busy_out[i] = |cnt_q[i];
    end
    any_rise = |rise_q;
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// tb_fsm_input_conditioner
// This bench uses directed vectors, with DEBOUNCE_CYCLES set to 4.
// Expected pulse events go into a scoreboard queue, tagged with the edge at
// which they must appear. A negedge monitor pops and checks an entry each
// time the DUT shows a rise or fall pulse.
module tb_fsm_input_conditioner;

  localparam int N_CH = 4;
  localparam int DEB  = 4;

  logic            clk;
  logic            rst;
  logic            ena;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] rise_out;
  logic [N_CH-1:0] fall_out;
  logic [N_CH-1:0] busy_out;
  logic            any_rise;

  typedef struct {
    int              edge_no;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] level;
  } pulse_t;

  pulse_t expQ[$];
  int     edgeCnt    = 0;
  int     assertions = 0;
  int     failures   = 0;

  fsm_input_conditioner #(
    .N_CH           (N_CH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .raw_in   (raw_in),
    .level_out(level_out),
    .rise_out (rise_out),
    .fall_out (fall_out),
    .busy_out (busy_out),
    .any_rise (any_rise)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so expected pulses can be pinned to an exact edge
  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] raw, input logic en, input logic rs);
    raw_in = raw;
    ena    = en;
    rst    = rs;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue a pulse expected 'offset' edges after the current one
  task automatic expectPulse(input int offset, input logic [N_CH-1:0] r,
                             input logic [N_CH-1:0] f, input logic [N_CH-1:0] lv);
    pulse_t p;
    p.edge_no = edgeCnt + offset;
    p.rise    = r;
    p.fall    = f;
    p.level   = lv;
    expQ.push_back(p);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " level"}, 32'(level_out), 32'h0);
    checkOutput({tag, " rise"},  32'(rise_out),  32'h0);
    checkOutput({tag, " fall"},  32'(fall_out),  32'h0);
    checkOutput({tag, " busy"},  32'(busy_out),  32'h0);
    checkOutput({tag, " any"},   32'(any_rise),  32'h0);
  endtask

  // Monitor: each pulse the DUT presents is matched against the head of the scoreboard
  always @(negedge clk) begin
    if ((|rise_out) || (|fall_out)) begin
      if (expQ.size() == 0) begin
        assertions++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: rise=%0h fall=%0h at edge %0d, none expected",
                 rise_out, fall_out, edgeCnt);
      end else begin
        pulse_t p;
        p = expQ.pop_front();
        checkOutput("pulse_edge",  32'(edgeCnt),   32'(p.edge_no));
        checkOutput("pulse_rise",  32'(rise_out),  32'(p.rise));
        checkOutput("pulse_fall",  32'(fall_out),  32'(p.fall));
        checkOutput("pulse_level", 32'(level_out), 32'(p.level));
        checkOutput("pulse_any",   32'(any_rise),  32'(|p.rise));
      end
    end
  end

  initial begin
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepEdges(2);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    $display("[TB] reset state");
    checkAllZero("reset");

    // Channel 0 rising: the level appears 6 edges after the raw change
    $display("[TB] ch0 rise latency");
    applyStimulus(4'b0001, 1'b1, 1'b0);
    expectPulse(6, 4'b0001, 4'b0000, 4'b0001);
    stepEdges(5);
    checkOutput("ch0 level_before", 32'(level_out[0]), 32'h0);
    checkOutput("ch0 busy_before",  32'(busy_out[0]),  32'h1);
    stepEdges(1);
    checkOutput("ch0 level_after",  32'(level_out), 32'h1);
    checkOutput("ch0 rise_now",     32'(rise_out),  32'h1);
    stepEdges(1);
    checkOutput("ch0 rise_gone",    32'(rise_out),  32'h0);
    checkOutput("ch0 any_gone",     32'(any_rise),  32'h0);

    // Channel 1 glitch of 3 cycles must be rejected
    $display("[TB] ch1 glitch");
    applyStimulus(4'b0011, 1'b1, 1'b0);
    stepEdges(3);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    stepEdges(1);
    checkOutput("glitch busy_pending", 32'(busy_out[1]), 32'h1);
    stepEdges(3);
    checkOutput("glitch busy_clear",   32'(busy_out[1]), 32'h0);
    checkOutput("glitch level",        32'(level_out),   32'h1);

    // Channel 2 rises, then falls
    $display("[TB] ch2 rise then fall");
    applyStimulus(4'b0101, 1'b1, 1'b0);
    expectPulse(6, 4'b0100, 4'b0000, 4'b0101);
    stepEdges(8);
    checkOutput("ch2 level_high", 32'(level_out), 32'h5);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    expectPulse(6, 4'b0000, 4'b0100, 4'b0001);
    stepEdges(8);
    checkOutput("ch2 level_low",  32'(level_out), 32'h1);

    // Channel 3 change interrupted by reset at the 4th edge
    $display("[TB] reset mid-count");
    applyStimulus(4'b1001, 1'b1, 1'b0);
    stepEdges(3);
    applyStimulus(4'b1001, 1'b1, 1'b1);
    stepEdges(1);
    checkAllZero("midreset");
    applyStimulus(4'b1001, 1'b1, 1'b0);
    expectPulse(6, 4'b1001, 4'b0000, 4'b1001);
    stepEdges(5);
    checkOutput("postreset level_before", 32'(level_out), 32'h0);
    stepEdges(1);
    checkOutput("postreset level_after",  32'(level_out), 32'h9);
    stepEdges(2);

    // Channel 1 frozen by ena=0 at counter value 2
    $display("[TB] enable freeze");
    applyStimulus(4'b1011, 1'b1, 1'b0);
    stepEdges(4);
    checkOutput("ena busy_at2", 32'(busy_out[1]), 32'h1);
    applyStimulus(4'b1011, 1'b0, 1'b0);
    stepEdges(10);
    checkOutput("ena level_held", 32'(level_out),   32'h9);
    checkOutput("ena busy_held",  32'(busy_out[1]), 32'h1);
    applyStimulus(4'b1011, 1'b1, 1'b0);
    expectPulse(2, 4'b0010, 4'b0000, 4'b1011);
    stepEdges(1);
    checkOutput("ena level_1edge", 32'(level_out), 32'h9);
    stepEdges(1);
    checkOutput("ena level_2edge", 32'(level_out), 32'hB);
    stepEdges(2);

    // All four channels rise together after a fresh reset
    $display("[TB] all channels simultaneous");
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepEdges(2);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkAllZero("reset2");
    applyStimulus(4'b1111, 1'b1, 1'b0);
    expectPulse(6, 4'b1111, 4'b0000, 4'b1111);
    stepEdges(6);
    checkOutput("all level",    32'(level_out), 32'hF);
    checkOutput("all any_rise", 32'(any_rise),  32'h1);
    stepEdges(1);
    checkOutput("all any_gone", 32'(any_rise),  32'h0);
    checkOutput("all rise_gone", 32'(rise_out), 32'h0);

    stepEdges(4);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
